// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared helpers for the parametrised synchronous FIFO.
// Provides the pointer-width function, the threshold compare used by the
// almost_* flags, and the status-flag bundle.
package sync_fifo_pkg;

  // Pointer width: index bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // True when level has reached (is at or above) thresh.
  function automatic logic thresh_reached(input int level, input int thresh);
    return (level >= thresh);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_WIDTH storage, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store the word on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised synchronous FIFO with occupancy count,
// almost-full/almost-empty thresholds and overflow/underflow pulses.
// Optional build macro SYNC_FIFO_FWFT_EN selects first-word fall-through:
// data_out shows the head entry directly and rd_valid = !empty. Without it
// the FIFO uses a registered read (data_out updates on the read edge).
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH - 1) begin : g_bad_afull
    $error("sync_fifo_param: AFULL_THRESH out of range 1..DEPTH-1");
  end
  if (AEMPTY_THRESH < 1 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_param: AEMPTY_THRESH out of range 1..DEPTH-1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_param: DATA_WIDTH must be at least 1");
  end

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  wr_ok;
  logic                  rd_ok;
  fifo_status_t          status;

  // Flags decode from registered state only, so no request input reaches an output.
  always_comb begin
    status.empty        = (wr_ptr == rd_ptr);
    status.full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                          (wr_ptr[AW] != rd_ptr[AW]);
    status.almost_full  = thresh_reached(int'(count_q), AFULL_THRESH);
    status.almost_empty = thresh_reached(AEMPTY_THRESH, int'(count_q));
  end

  assign wr_ok = wr_en && !status.full;
  assign rd_ok = rd_en && !status.empty;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (mem_rd_data)
  );

  // Pointers and occupancy; pointers wrap modulo 2*DEPTH through the extra MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !rd_ok)      count_q <= count_q + 1'b1;
      else if (rd_ok && !wr_ok) count_q <= count_q - 1'b1;
    end
  end

  // Error pulses: one cycle high after a request that hit a full/empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && status.full;
      underflow <= rd_en && status.empty;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = mem_rd_data;
  assign rd_valid = !status.empty;
`else
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  rd_valid_q;

  // Registered read: capture the head word on an accepted read, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_ok;
      if (rd_ok) dout_q <= mem_rd_data;
    end
  end

  assign data_out = dout_q;
  assign rd_valid = rd_valid_q;
`endif

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench for sync_fifo_param (default params).
// Covers both read modes depending on SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFT   = DEPTH - 2;
  localparam int AET   = 2;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] m_q[$];
  logic [DW-1:0] last_dout;

  sync_fifo_param #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AFT),
    .AEMPTY_THRESH (AET)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status(input logic exp_ovf, input logic exp_unf);
    int n;
    n = m_q.size();
    check("count",        32'(count),        32'(n));
    check("full",         32'(full),         32'(n == DEPTH));
    check("empty",        32'(empty),        32'(n == 0));
    check("almost_full",  32'(almost_full),  32'(n >= AFT));
    check("almost_empty", 32'(almost_empty), 32'(n <= AET));
    check("overflow",     32'(overflow),     32'(exp_ovf));
    check("underflow",    32'(underflow),    32'(exp_unf));
  endtask

  // One clock: drive request, update scoreboard at the edge, check #1 later.
  task automatic step(input logic we, input logic re, input logic [DW-1:0] din);
    logic          w_acc, r_acc, e_ovf, e_unf;
    logic [DW-1:0] exp_d;
    exp_d   = '0;
    wr_en   = we;
    rd_en   = re;
    data_in = din;
    e_ovf   = we && (m_q.size() == DEPTH);
    e_unf   = re && (m_q.size() == 0);
    w_acc   = we && !e_ovf;
    r_acc   = re && !e_unf;
    @(posedge clk);
    if (r_acc) exp_d = m_q.pop_front();
    if (w_acc) m_q.push_back(din);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
    check("rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("head", 32'(data_out), 32'(m_q[0]));
`else
    if (r_acc) last_dout = exp_d;
    check("rd_valid", 32'(rd_valid), 32'(r_acc));
    check("data_out", 32'(data_out), 32'(last_dout));
`endif
    check_status(e_ovf, e_unf);
  endtask

  task automatic check_reset_state();
    check("rst_count", 32'(count),        32'd0);
    check("rst_empty", 32'(empty),        32'd1);
    check("rst_aempty",32'(almost_empty), 32'd1);
    check("rst_full",  32'(full),         32'd0);
    check("rst_afull", 32'(almost_full),  32'd0);
    check("rst_ovf",   32'(overflow),     32'd0);
    check("rst_unf",   32'(underflow),    32'd0);
    check("rst_valid", 32'(rd_valid),     32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    check("rst_dout",  32'(data_out),     32'd0);
`endif
  endtask

  initial begin
    logic [DW-1:0] d;
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    data_in   = '0;
    last_dout = '0;
    #22;
    check_reset_state();
    rst_n = 1'b1;
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);

    // Fill to full, then overflow pulse for exactly one cycle.
    for (int i = 1; i <= DEPTH; i++) step(1, 0, 8'(i));
    step(1, 0, 8'h11);
    step(0, 0, 8'h00);

    // Drain in order, then underflow.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);

    // Steady state at count 8 across pointer wrap.
    d = 8'h20;
    for (int i = 0; i < 8; i++) begin step(1, 0, d); d++; end
    for (int i = 0; i < 40; i++) begin step(1, 1, d); d++; end
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00);

    // Simultaneous requests at full and at empty.
    for (int i = 0; i < DEPTH; i++) begin step(1, 0, d); d++; end
    step(1, 1, 8'hEE);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 8'h00);
    step(1, 1, 8'h77);
    step(0, 1, 8'h00);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

    // Asynchronous reset mid-burst, between clock edges.
    for (int i = 0; i < 5; i++) begin step(1, 0, d); d++; end
    #3;
    rst_n = 1'b0;
    #1;
    m_q.delete();
    last_dout = '0;
    check_reset_state();
    #2;
    rst_n = 1'b1;
    step(1, 0, 8'hA5);
    step(0, 1, 8'h00);
    step(1, 0, 8'h5A);
    step(1, 1, 8'hC3);
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO, successor to the team's fixed 8-deep FIFO: configurable width and depth, all DEPTH entries usable, occupancy count, programmable almost-full/almost-empty thresholds, and overflow/underflow error pulses. It sits between a producer and a consumer in the same clock domain. It is the default buffering primitive for new datapath blocks.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AFULL_THRESH, DEPTH-2, almost_full asserts when count ≥ this value (1..DEPTH-1)
- AEMPTY_THRESH, 2, almost_empty asserts when count ≤ this value (1..DEPTH-1)
- clk  input  1  single clock; all state changes on its rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- wr_en  input  1  write request
- data_in  input  DATA_WIDTH  write data
- rd_en  input  1  read request (pop in FWFT mode)
- data_out  output  DATA_WIDTH  read data
- rd_valid  output  1  data_out holds a valid popped/head word
- full, empty  output  1 each  occupancy flags
- almost_full, almost_empty  output  1 each  threshold flags
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow, underflow  output  1 each  one-cycle error pulses

## Operation
- Pointers are $clog2(DEPTH)+1 bits; low bits index storage, MSB is the wrap bit. empty when pointers equal; full when low bits equal and MSBs differ. Pointers wrap naturally modulo 2·DEPTH.
- Write accepted when wr_en && !full; read accepted when rd_en && !empty. Each check uses pre-edge flags.
- Both accepted in the same cycle: count unchanged, both pointers advance.
- At full with wr_en && rd_en: only the read is accepted; the write is dropped and overflow pulses. At empty with both: only the write is accepted; underflow pulses.
- count is a register: +1 on write only, −1 on read only, unchanged otherwise. full/empty/almost_* are decoded combinationally from the registered state.
- overflow is registered high for exactly one cycle after an edge where wr_en && full. underflow behaves the same for rd_en && empty. State is unchanged by a rejected request.
- Reset (asynchronous, any time, including mid-burst) clears pointers, count, data_out, rd_valid, overflow and underflow to 0. Resulting flags: empty=1, almost_empty=1, full=0, almost_full=0. Storage contents are not reset and are considered discarded.
- Invalid parameters (non-power-of-two DEPTH, DEPTH<4, out-of-range thresholds) cause an elaboration-time error.

## Timing
- Standard mode: an accepted read at edge N updates data_out at edge N. rd_valid is high for the cycle after edge N only. data_out holds its value otherwise.
- Write at edge N: count and flags reflect it from edge N. In standard mode the word can be read from edge N+1.
- No combinational path from wr_en/rd_en to any output.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word fall-through.
  - data_out presents the head entry continuously while !empty, with zero-latency visibility: the word written at edge N is on data_out after edge N.
  - rd_valid = !empty; rd_en acknowledges and pops the head.
  - The data_out register is removed.
- Not defined: standard registered-read mode as described above.

## Structure
- Package sync_fifo_pkg: function for pointer width ($clog2(DEPTH)+1), threshold-check helper, and a status-flag struct typedef (full, empty, almost_full, almost_empty).
- Sub-module sync_fifo_mem: DEPTH×DATA_WIDTH array with one synchronous write port and an asynchronous read port. The top level holds pointers, count, flags, the output register and the error pulses.

## Test plan
- Reset then idle: count=0, empty=1, almost_empty=1, full=0, data_out=0, no pulses.
- Write 16 words 0x01..0x10 back-to-back: full=1 and count=16 after the 16th edge; almost_full first high at count=14. 17th write gives overflow pulse for one cycle, count stays 16.
- Read all 16 words: data_out sequence is 0x01..0x10 with rd_valid each cycle. empty=1 at end; one extra rd_en gives underflow pulse.
- Hold count=8, then drive wr_en=rd_en=1 for 40 cycles with incrementing data: count stays 8, order is preserved across pointer wrap, no error pulses.
- Full with wr_en=rd_en=1: read accepted, write dropped, overflow=1, count becomes 15. Empty with both: write accepted, underflow=1, count becomes 1.
- Assert rst_n low mid-burst between clock edges: outputs clear immediately. After release, the first write/read round-trip returns the new data. Repeat the suite with SYNC_FIFO_FWFT_EN, checking head visibility one edge after the write.
